// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: segment codes, digit count
// and the frame-capture FSM encoding.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment codes, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational segment-pattern to hex-nibble decoder; inverse of the
// hex-to-segment encoder. o_valid drops for any pattern outside the 16 codes.
module sseg_to_hex
  import stopwatch_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_valid
);

  always_comb begin
    o_nib   = 4'h0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0:   o_nib = 4'h0;
      SEG_1:   o_nib = 4'h1;
      SEG_2:   o_nib = 4'h2;
      SEG_3:   o_nib = 4'h3;
      SEG_4:   o_nib = 4'h4;
      SEG_5:   o_nib = 4'h5;
      SEG_6:   o_nib = 4'h6;
      SEG_7:   o_nib = 4'h7;
      SEG_8:   o_nib = 4'h8;
      SEG_9:   o_nib = 4'h9;
      SEG_A:   o_nib = 4'hA;
      SEG_B:   o_nib = 4'hB;
      SEG_C:   o_nib = 4'hC;
      SEG_D:   o_nib = 4'hD;
      SEG_E:   o_nib = 4'hE;
      SEG_F:   o_nib = 4'hF;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Reconstructs the 4-digit value shown on a multiplexed 7-segment display by
// sniffing its an/sseg/dp drive lines and debouncing each digit dwell.
// Output handshake: frame_valid is a one-cycle strobe with no back-pressure;
// value/dp_mask change only in that cycle and hold until the next strobe.
module sseg_capture
  import stopwatch_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  c_clk,
  input  logic                  R,
  input  logic [NUM_DIGITS-1:0] an,
  input  logic [6:0]            sseg,
  input  logic                  dp,
  output logic [15:0]           value,
  output logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  frame_valid,
  output logic                  seg_err,
  output logic                  an_err,
  output cap_state_t            o_dbg_state
);

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 2);

  logic [NUM_DIGITS-1:0] r_an, r_prev_an;
  logic [6:0]            r_sseg, r_prev_sseg;
  logic                  r_dp, r_prev_dp;
  logic [7:0]            r_cnt;

  logic [NUM_DIGITS-1:0]      r_seen, w_seen_next;
  logic                       r_bad, w_bad_next;
  logic [NUM_DIGITS-1:0][3:0] r_shadow, w_shadow_next;
  logic [NUM_DIGITS-1:0]      r_sdp, w_sdp_next;

  cap_state_t r_state, w_state_next;
  logic       w_clr_frame;

  logic       w_changed, w_blank, w_onehot, w_multi, w_at_acc;
  logic       w_acc, w_acc_ok, w_acc_bad, w_publish;
  logic [3:0] w_nib;
  logic       w_nib_valid;

  sseg_to_hex u_dec (
    .i_seg   (r_sseg),
    .o_nib   (w_nib),
    .o_valid (w_nib_valid)
  );

  always_ff @(posedge c_clk) begin
    if (R) begin
      r_an        <= '0;
      r_sseg      <= '0;
      r_dp        <= 1'b0;
      r_prev_an   <= '0;
      r_prev_sseg <= '0;
      r_prev_dp   <= 1'b0;
    end else begin
      r_an        <= an;
      r_sseg      <= sseg;
      r_dp        <= dp;
      r_prev_an   <= r_an;
      r_prev_sseg <= r_sseg;
      r_prev_dp   <= r_dp;
    end
  end

  assign w_changed = {r_an, r_sseg, r_dp} != {r_prev_an, r_prev_sseg, r_prev_dp};
  assign w_blank   = (r_an == '0);
  assign w_onehot  = !w_blank && ((r_an & (r_an - 4'd1)) == '0);
  assign w_multi   = !w_blank && !w_onehot;

  // Counter reaches STABLE_CYCLES-1 on the STABLE_CYCLES-th identical sample,
  // then saturates so the accept point occurs once per dwell.
  always_ff @(posedge c_clk) begin
    if (R || w_blank || w_changed) r_cnt <= '0;
    else if (r_cnt != CNT_SAT)     r_cnt <= r_cnt + 8'd1;
  end

  assign w_at_acc  = !w_blank && !w_changed && (r_cnt == CNT_ACC);
  assign w_acc     = w_at_acc && w_onehot;
  assign w_acc_ok  = w_acc && w_nib_valid;
  assign w_acc_bad = w_acc && !w_nib_valid;

  always_ff @(posedge c_clk) begin
    if (R) r_state <= ST_IDLE;
    else   r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc) w_state_next = ST_COLLECT;
      ST_COLLECT: if (w_seen_next == '1) w_state_next = ST_PUBLISH;
      ST_PUBLISH: w_state_next = ST_COLLECT;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clr_frame = (r_state == ST_PUBLISH);
  end

  assign o_dbg_state = r_state;

  // An accept landing in the PUBLISH cycle starts the next frame.
  always_comb begin
    w_seen_next   = w_clr_frame ? '0 : r_seen;
    w_bad_next    = w_clr_frame ? 1'b0 : r_bad;
    w_shadow_next = r_shadow;
    w_sdp_next    = r_sdp;
    if (w_acc_bad) w_bad_next = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_acc_ok && r_an[k]) begin
        w_shadow_next[k] = w_nib;
        w_sdp_next[k]    = ~r_dp;
        w_seen_next[k]   = 1'b1;
      end
    end
  end

  assign w_publish = (w_state_next == ST_PUBLISH) && !w_bad_next;

  always_ff @(posedge c_clk) begin
    if (R) begin
      r_seen      <= '0;
      r_bad       <= 1'b0;
      r_shadow    <= '0;
      r_sdp       <= '0;
      value       <= '0;
      dp_mask     <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      r_seen      <= w_seen_next;
      r_bad       <= w_bad_next;
      r_shadow    <= w_shadow_next;
      r_sdp       <= w_sdp_next;
      frame_valid <= w_publish;
      seg_err     <= w_acc_bad;
      an_err      <= w_at_acc && w_multi;
      if (w_publish) begin
        value   <= w_shadow_next;
        dp_mask <= w_sdp_next;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: expected frames are queued by the stimulus
// and checked by an independent monitor whenever frame_valid strobes.
module tb_sseg_capture;
  import stopwatch_pkg::*;

  logic        c_clk = 1'b0;
  logic        R = 1'b1;
  logic [3:0]  an = 4'b0000;
  logic [6:0]  sseg = 7'h7F;
  logic        dp = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        frame_valid, seg_err, an_err;
  cap_state_t  o_dbg_state;

  sseg_capture #(.STABLE_CYCLES(4)) dut (
    .c_clk       (c_clk),
    .R           (R),
    .an          (an),
    .sseg        (sseg),
    .dp          (dp),
    .value       (value),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset bookkeeping
  always #5 c_clk = ~c_clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge c_clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= R;
  end

  // scoreboard state
  logic [19:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int n_fr = 0, n_seg = 0, n_an = 0;
  int fv_cyc = 0;
  bit mon_en = 1'b0;
  logic [19:0] prev_obs = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge c_clk) begin
    if (mon_en) begin
      if (seg_err) n_seg++;
      if (an_err) n_an++;
      if (frame_valid) begin
        n_fr++;
        fv_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame actual=%0h expected=none", {value, dp_mask});
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if ({value, dp_mask} !== e) begin
            bad++;
            $display("FAIL frame actual=%0h expected=%0h", {value, dp_mask}, e);
          end
        end
      end else if (!rst_at_edge) begin
        total++;
        if ({value, dp_mask} !== prev_obs) begin
          bad++;
          $display("FAIL value_hold actual=%0h expected=%0h", {value, dp_mask}, prev_obs);
        end
      end
    end
    prev_obs = {value, dp_mask};
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  int d3_cyc = 0;

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; sseg = s; dp = d;
    repeat (n) begin @(posedge c_clk); #1; end
  endtask

  task automatic scan(input logic [27:0] pats, input logic [3:0] dpm, input bit glitch);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] a;
      a = 4'b0001 << k;
      if (glitch) drive(a, 7'h79, 1'b1, 2);
      if (k == 3) d3_cyc = cyc;
      drive(a, pats[k*7 +: 7], ~dpm[k], 8);
    end
  endtask

  task automatic pulse_reset();
    R = 1'b1; an = 4'b0000;
    @(posedge c_clk); #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_dp_mask", 32'(dp_mask), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_an_err", 32'(an_err), 32'h0);
    check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    R = 1'b0;
  endtask

  // {d3,d2,d1,d0} patterns
  localparam logic [27:0] P_5043 = {7'h12, 7'h40, 7'h19, 7'h30};
  localparam logic [27:0] P_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] P_1234_BAD = {7'h79, 7'h24, 7'h7F, 7'h19};

  int f0, s0, a0;

  initial begin
    repeat (3) @(posedge c_clk);
    #1;
    pulse_reset();
    mon_en = 1'b1;

    // clean scan
    f0 = n_fr; s0 = n_seg;
    exp_q.push_back({16'h5043, 4'b0100});
    scan(P_5043, 4'b0100, 1'b0);
    drive(4'b0000, 7'h7F, 1'b1, 10);
    check("clean_frames", 32'(n_fr - f0), 32'd1);
    check("clean_latency", 32'(fv_cyc - d3_cyc), 32'd5);
    check("clean_value", 32'(value), 32'h5043);
    check("clean_dp_mask", 32'(dp_mask), 32'h4);
    check("clean_seg_err", 32'(n_seg - s0), 32'd0);

    // glitch rejection
    f0 = n_fr; s0 = n_seg;
    exp_q.push_back({16'h5043, 4'b0100});
    scan(P_5043, 4'b0100, 1'b1);
    drive(4'b0000, 7'h7F, 1'b1, 10);
    check("glitch_frames", 32'(n_fr - f0), 32'd1);
    check("glitch_seg_err", 32'(n_seg - s0), 32'd0);

    // invalid segment on an=0010 spoils the frame; a later clean frame publishes
    f0 = n_fr; s0 = n_seg;
    scan(P_1234_BAD, 4'b0000, 1'b0);
    scan(P_1234, 4'b0000, 1'b0);
    check("bad_seg_err", 32'(n_seg - s0), 32'd1);
    check("bad_no_frame", 32'(n_fr - f0), 32'd0);
    check("bad_value_kept", 32'(value), 32'h5043);
    exp_q.push_back({16'h1234, 4'b0000});
    scan(P_1234, 4'b0000, 1'b0);
    drive(4'b0000, 7'h7F, 1'b1, 10);
    check("bad_next_frame", 32'(n_fr - f0), 32'd1);
    check("bad_next_value", 32'(value), 32'h1234);

    // an errors
    pulse_reset();
    f0 = n_fr; s0 = n_seg; a0 = n_an;
    drive(4'b0011, 7'h30, 1'b1, 8);
    check("multi_an_err", 32'(n_an - a0), 32'd1);
    drive(4'b0000, 7'h30, 1'b1, 20);
    check("blank_an_err", 32'(n_an - a0), 32'd1);
    check("anerr_frames", 32'(n_fr - f0), 32'd0);
    check("anerr_seg_err", 32'(n_seg - s0), 32'd0);
    check("anerr_state", 32'(o_dbg_state), 32'(ST_IDLE));

    // reset mid-frame, then a full 9999 scan
    exp_q.push_back({16'h5043, 4'b0100});
    scan(P_5043, 4'b0100, 1'b0);
    drive(4'b0001, 7'h10, 1'b1, 8);
    drive(4'b0010, 7'h10, 1'b1, 8);
    pulse_reset();
    f0 = n_fr;
    drive(4'b0001, 7'h10, 1'b1, 8);
    drive(4'b0010, 7'h10, 1'b1, 8);
    drive(4'b0100, 7'h10, 1'b1, 8);
    check("post_rst_no_frame", 32'(n_fr - f0), 32'd0);
    check("post_rst_value", 32'(value), 32'h0);
    exp_q.push_back({16'h9999, 4'b0000});
    drive(4'b1000, 7'h10, 1'b1, 8);
    drive(4'b0000, 7'h7F, 1'b1, 10);
    check("post_rst_frame", 32'(n_fr - f0), 32'd1);
    check("post_rst_9999", 32'(value), 32'h9999);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a digit (legal 2..255).
REQ-002 SHALL have port c_clk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port R  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port an  input  4  digit select, one-hot active-high; bit0 = rightmost digit.
REQ-005 SHALL have port sseg  input  7  segment pattern, active-low, bit0=a ... bit6=g.
REQ-006 SHALL have port dp  input  1  decimal point, active-low.
REQ-007 SHALL have port value  output  16  last complete frame; nibble k = digit selected by an[k].
REQ-008 SHALL have port dp_mask  output  4  last complete frame; bit k = 1 when dp was lit on digit k.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when value/dp_mask update.
REQ-010 SHALL have port seg_err  output  1  one-cycle pulse on an accepted undecodable pattern.
REQ-011 SHALL have port an_err  output  1  one-cycle pulse when the registered an is neither one-hot nor zero.

Function
REQ-012 SHALL register {an, sseg, dp} once on entry; all further logic uses the registered tuple.
REQ-013 SHALL decode sseg to hex: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex of 7-bit value); any other pattern is invalid.
REQ-014 SHALL run a dwell counter: clear when the registered tuple differs from the previous cycle's, otherwise increment, saturating at STABLE_CYCLES.
REQ-015 SHALL accept exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES-1 with an one-hot; no re-accept until the tuple changes.
REQ-016 SHALL treat an == 0 as blanking: counter held clear, no accept, no error.
REQ-017 SHALL treat a multi-hot an as an_err: pulse once per dwell at the accept point, counter held, no accept.
REQ-018 SHALL, on a valid accept, write the nibble and dp bit into shadow slot k and set seen[k]; a repeat of digit k before frame completion overwrites (latest wins).
REQ-019 SHALL, on an invalid accept, pulse seg_err in the accept cycle and set the bad flag.
REQ-020 SHALL implement FSM IDLE -> COLLECT on first accept; COLLECT -> PUBLISH when seen == 4'b1111; PUBLISH -> COLLECT after one cycle.
REQ-021 SHALL, in PUBLISH, copy shadow to value/dp_mask and pulse frame_valid if bad == 0; otherwise leave outputs unchanged and pulse nothing; in both cases clear seen and bad.
REQ-022 SHALL make frame_valid rise exactly 1 cycle after the fourth distinct-digit accept; value is stable in that cycle.
REQ-023 SHALL honour an accept that coincides with PUBLISH as the first digit of the next frame.
REQ-024 SHALL never let value or dp_mask change outside a frame_valid cycle.

Reset
REQ-025 SHALL, on R high at a clock edge, set value=0, dp_mask=0, frame_valid=0, seg_err=0, an_err=0, seen=0, bad=0, counter=0, input register=0, FSM=IDLE.
REQ-026 SHALL, on reset mid-frame, discard partial shadow data; the first frame after reset requires all four digits anew.

Structure
REQ-027 SHALL take the 16 segment constants, the digit count (4) and the FSM state encoding from shared package stopwatch_pkg.
REQ-028 SHALL instantiate one combinational sub-module, sseg_to_hex (7-bit in -> 4-bit nibble + valid), the inverse of the existing hex-to-segment encoder.

Verification
REQ-029 SHALL verify a clean scan: an cycling 0001/0010/0100/1000 with patterns 30/19/40/12, dp low on an=0100, 8 cycles each -> frame_valid once, value=16'h5043, dp_mask=4'b0100.
REQ-030 SHALL verify glitch rejection: STABLE_CYCLES=4, a 2-cycle pattern 79 inserted before each digit -> same value as REQ-029, no seg_err.
REQ-031 SHALL verify an invalid segment: pattern 7F on an=0010 -> seg_err pulses once, no frame_valid for that frame, value unchanged, next clean frame publishes.
REQ-032 SHALL verify an errors: an=0011 for 8 cycles -> one an_err pulse, no accept; an=0000 for 20 cycles -> no pulses.
REQ-033 SHALL verify reset: R asserted after 2 of 4 digits -> all outputs 0 next edge; a following full scan of 9999 -> value=16'h9999 only after all four digits.
